// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
//   - access size encodings (SZ_*)
//   - 2-bit FSM state codes and the enum built on them
//   - byte-enable constants for word / low half / high half
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        ISSUE  = S_ISSUE,
        RDWAIT = S_RDWAIT,
        RESP   = S_RESP
    } state_t;

    localparam logic [3:0] BE_ALL = 4'b1111;
    localparam logic [3:0] BE_LO  = 4'b0011;
    localparam logic [3:0] BE_HI  = 4'b1100;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-memory bus.
//   slave  : the access unit's view (takes requests, drives memory)
//   master : the environment's view (pipeline + memory model)
interface mem_access_unit_if #(
    parameter int WIDTH_D = 32,
    parameter int WIDTH_A = 32
);
    // pipeline request
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [WIDTH_A-1:0] req_addr;
    logic [WIDTH_D-1:0] req_wdata;
    // pipeline response
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH_D-1:0] rsp_rdata;
    logic               rsp_err;
    // data memory
    logic               mem_req;
    logic               mem_gnt;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [WIDTH_A-3:0] mem_addr;
    logic [WIDTH_D-1:0] mem_wdata;
    logic               mem_rvalid;
    logic [WIDTH_D-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_lane_extend.sv
// Load-data lane select and extension (combinational).
//   rdata       : raw memory word
//   lane        : byte offset addr[1:0] of the access
//   size        : SZ_B / SZ_H / SZ_W
//   is_unsigned : zero-extend instead of sign-extend
//   data        : right-justified, extended load value
module load_lane_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [31:0] sh;

    always_comb begin
        sh = rdata >> {lane, 3'b000};
        case (size)
            SZ_B:    data = {{24{sh[7]  & ~is_unsigned}}, sh[7:0]};
            SZ_H:    data = {{16{sh[15] & ~is_unsigned}}, sh[15:0]};
            // word accesses are aligned, so lane is 0 and sh == rdata
            default: data = sh;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake to the pipeline and
//                request/grant + read-valid bus to a synchronous data memory
// One access in flight at a time: IDLE -> ISSUE -> (RDWAIT) -> RESP -> IDLE.
// Misaligned / illegal-size requests jump straight to RESP with rsp_err.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int WIDTH_D = 32,
    parameter int WIDTH_A = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_unit_if.slave bus
);
    state_t             state, state_nxt;
    logic               err_in;
    logic [3:0]         be_pk;
    logic [WIDTH_D-1:0] wdata_pk;
    logic [WIDTH_D-1:0] ld_data;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic               uns_q;

    // Alignment check and store packing on the incoming request.
    always_comb begin
        err_in   = (bus.req_size == 2'b11) ||
                   (bus.req_size == SZ_H && bus.req_addr[0]) ||
                   (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00);
        be_pk    = BE_ALL;
        wdata_pk = bus.req_wdata;
        case (bus.req_size)
            SZ_B: begin
                be_pk    = 4'b0001 << bus.req_addr[1:0];
                wdata_pk = {4{bus.req_wdata[7:0]}};
            end
            SZ_H: begin
                be_pk    = bus.req_addr[1] ? BE_HI : BE_LO;
                wdata_pk = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_nxt = err_in ? RESP : ISSUE;
            ISSUE:   if (bus.mem_gnt)    state_nxt = bus.mem_we ? RESP : RDWAIT;
            RDWAIT:  if (bus.mem_rvalid) state_nxt = RESP;
            RESP:    if (bus.rsp_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE);

    load_lane_extend u_ext (
        .rdata       (bus.mem_rdata),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            lane_q        <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.mem_we    <= bus.req_we;
                    bus.mem_be    <= be_pk;
                    bus.mem_addr  <= bus.req_addr[WIDTH_A-1:2];
                    bus.mem_wdata <= wdata_pk;
                    lane_q        <= bus.req_addr[1:0];
                    size_q        <= bus.req_size;
                    uns_q         <= bus.req_unsigned;
                    // an error never reaches the memory
                    bus.mem_req   <= ~err_in;
                    bus.rsp_valid <= err_in;
                    bus.rsp_err   <= err_in;
                    bus.rsp_rdata <= '0;
                end
                ISSUE: if (bus.mem_gnt) begin
                    bus.mem_req <= 1'b0;
                    if (bus.mem_we) bus.rsp_valid <= 1'b1;
                end
                RDWAIT: if (bus.mem_rvalid) begin
                    bus.rsp_rdata <= ld_data;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
